// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle RV32M multiply/divide unit for the execute stage. Computes all
// eight M-extension operations on two 32-bit register operands and returns a
// registered 32-bit result together with the destination register address.
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies are done with a single
//                       33x33 signed product in IDLE and go straight to FIN;
//                       the iterative MUL state is not compiled. Divides are
//                       identical in both builds.
//
// Ports:
//   CLK     in   1  clock, rising edge
//   RESET   in   1  synchronous active-high reset
//   START   in   1  request a new operation (sampled only while BUSY=0)
//   FUNC    in   3  RV32M funct3 (000 MUL .. 111 REMU)
//   DATA1   in  32  rs1 operand (multiplicand / dividend)
//   DATA2   in  32  rs2 operand (multiplier / divisor)
//   RD_IN   in   5  destination register address
//   RESULT  out 32  registered result, held until the next FIN
//   RD_OUT  out  5  registered destination address for RESULT
//   BUSY    out  1  an operation is in progress
//   DONE    out  1  one-cycle pulse, RESULT/RD_OUT valid
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  FUNC,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [4:0]  RD_IN,
    output logic [31:0] RESULT,
    output logic [4:0]  RD_OUT,
    output logic        BUSY,
    output logic        DONE
);

`ifdef MULDIV_FAST_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;
`endif

    state_t      state;
    state_t      next_state;

    logic [2:0]  func_q;
    logic [4:0]  rd_q;
    // Shared work register: product accumulator for multiply,
    // {partial remainder, dividend/quotient} for divide, or a finished
    // raw value when bypass is set.
    logic [63:0] work;
    logic [31:0] operand_q;
    logic        sign_a;
    logic        sign_b;
    logic        bypass;
    logic [5:0]  count;

    // ------------------------------------------------------------------
    // Operand decode for the operation being requested in IDLE
    // ------------------------------------------------------------------
    logic        is_div;
    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_val;

    always_comb begin
        is_div   = FUNC[2];
        a_signed = is_div ? ~FUNC[0] : ((FUNC == 3'b001) || (FUNC == 3'b010));
        b_signed = is_div ? ~FUNC[0] : (FUNC == 3'b001);
        a_neg    = a_signed & DATA1[31];
        b_neg    = b_signed & DATA2[31];
        a_abs    = a_neg ? (32'd0 - DATA1) : DATA1;
        b_abs    = b_neg ? (32'd0 - DATA2) : DATA2;
        div_zero = is_div && (DATA2 == 32'd0);
        div_ovf  = is_div && ~FUNC[0] && (DATA1 == 32'h8000_0000) &&
                   (DATA2 == 32'hFFFF_FFFF);
        // Divide-by-zero and signed overflow have fixed architectural results
        if (div_zero) begin
            special_val = FUNC[1] ? DATA1 : 32'hFFFF_FFFF;
        end else begin
            special_val = FUNC[1] ? 32'd0 : 32'h8000_0000;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign/zero extension to 33 bits then to 64; the low 64 bits of the
    // signed product are all any multiply variant needs.
    logic signed [63:0] fast_a;
    logic signed [63:0] fast_b;
    logic signed [63:0] fast_prod;

    always_comb begin
        fast_a    = {{32{a_signed & DATA1[31]}}, DATA1};
        fast_b    = {{32{b_signed & DATA2[31]}}, DATA2};
        fast_prod = fast_a * fast_b;
    end
`else
    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole register right by one.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand_q} : 33'd0);
        mul_next = {mul_sum, work[31:1]};
    end
`endif

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_sub;
    logic [63:0] div_next;

    always_comb begin
        div_shift = {work[63:32], work[31]};
        div_fits  = (div_shift >= {1'b0, operand_q});
        div_sub   = div_shift[31:0] - operand_q;
        if (div_fits) begin
            div_next = {div_sub, work[30:0], 1'b1};
        end else begin
            div_next = {div_shift[31:0], work[30:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection used in FIN
    // ------------------------------------------------------------------
    logic [63:0] prod_fixed;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] fin_result;

    always_comb begin
        prod_fixed = (sign_a ^ sign_b) ? (64'd0 - work) : work;
        quo_fixed  = (sign_a ^ sign_b) ? (32'd0 - work[31:0]) : work[31:0];
        rem_fixed  = sign_a ? (32'd0 - work[63:32]) : work[63:32];
        if (bypass) begin
            // Raw value already final: low word for MUL and divides,
            // high word for the MULH family.
            if (func_q[2] || (func_q[1:0] == 2'b00)) begin
                fin_result = work[31:0];
            end else begin
                fin_result = work[63:32];
            end
        end else if (func_q[2]) begin
            fin_result = func_q[1] ? rem_fixed : quo_fixed;
        end else if (func_q[1:0] == 2'b00) begin
            fin_result = prod_fixed[31:0];
        end else begin
            fin_result = prod_fixed[63:32];
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and BUSY
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        BUSY       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (is_div) begin
                        next_state = (div_zero || div_ovf) ? S_FIN : S_DIV;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        next_state = S_FIN;
`else
                        next_state = S_MUL;
`endif
                    end
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            S_MUL: begin
                if (count == 6'd31) begin
                    next_state = S_FIN;
                end
            end
`endif
            S_DIV: begin
                if (count == 6'd31) begin
                    next_state = S_FIN;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, iteration and result registration
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            func_q    <= 3'd0;
            rd_q      <= 5'd0;
            work      <= 64'd0;
            operand_q <= 32'd0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            bypass    <= 1'b0;
            count     <= 6'd0;
            RESULT    <= 32'd0;
            RD_OUT    <= 5'd0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        func_q    <= FUNC;
                        rd_q      <= RD_IN;
                        sign_a    <= a_neg;
                        sign_b    <= b_neg;
                        count     <= 6'd0;
                        operand_q <= is_div ? b_abs : a_abs;
                        if (is_div) begin
                            if (div_zero || div_ovf) begin
                                work   <= {32'd0, special_val};
                                bypass <= 1'b1;
                            end else begin
                                work   <= {32'd0, a_abs};
                                bypass <= 1'b0;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            work   <= fast_prod;
                            bypass <= 1'b1;
`else
                            work   <= {32'd0, b_abs};
                            bypass <= 1'b0;
`endif
                        end
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                S_MUL: begin
                    work  <= mul_next;
                    count <= count + 6'd1;
                end
`endif
                S_DIV: begin
                    work  <= div_next;
                    count <= count + 6'd1;
                end
                S_FIN: begin
                    RESULT <= fin_result;
                    RD_OUT <= rd_q;
                    DONE   <= 1'b1;
                    count  <= 6'd0;
                end
                default: begin
                    count <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Scoreboard bench for muldiv_unit. Each issued operation pushes its expected
// result, destination and latency (from an arithmetic reference model) into a
// queue; an independent monitor pops and compares on every DONE pulse.
// Define MULDIV_FAST_MUL_EN for both bench and RTL to check the fast build.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  FUNC;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  RD_IN;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;
    logic        BUSY;
    logic        DONE;

    muldiv_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNC   (FUNC),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RD_IN  (RD_IN),
        .RESULT (RESULT),
        .RD_OUT (RD_OUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          issue;
        int          lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    // Architectural RV32M results computed with wide plain arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p;
        int     ia = a;
        int     ib = b;
        logic   ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Edges from acceptance edge E0 to the edge that raises DONE
    function automatic int refLatency(input logic [2:0] f,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] req);
        check_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Waits for BUSY low (bounded), then issues one operation and records
    // its expectation. done_at_issue reports DONE at the moment of issue.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input string name, output logic done_at_issue);
        int guard = 0;
        while (BUSY !== 1'b0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        done_at_issue = DONE;
        if (BUSY !== 1'b0) begin
            check_cnt++;
            $display("[TB] FAIL %s_issue: BUSY stuck at %b, required 0", name, BUSY);
        end else begin
            FUNC  = f;
            DATA1 = a;
            DATA2 = b;
            RD_IN = rd;
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
            exp_q.push_back('{refModel(f, a, b), rd, cyc, refLatency(f, a, b), name});
        end
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check_cnt++;
            $display("[TB] FAIL drain_timeout: %0d ops pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every DONE pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("[TB] FAIL unexpected_done: DONE=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.name, "_result"}, RESULT, e.result);
                    checkOutput({e.name, "_rd"}, 32'(RD_OUT), 32'(e.rd));
                    checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic dn;
        logic [2:0] f;
        logic [31:0] a;
        logic [31:0] b;

        RESET = 1'b1;
        START = 1'b0;
        FUNC  = 3'd0;
        DATA1 = 32'd0;
        DATA2 = 32'd0;
        RD_IN = 5'd0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_busy",   32'(BUSY),   32'd0);
        checkOutput("reset_done",   32'(DONE),   32'd0);
        checkOutput("reset_result", RESULT,      32'd0);
        checkOutput("reset_rd",     32'(RD_OUT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        $display("[TB] directed operations");
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd5, "div_m7_2", dn);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd6, "rem_m7_2", dn);
        applyStimulus(3'd5, 32'd100, 32'd0, 5'd7, "divu_by0", dn);
        applyStimulus(3'd7, 32'd100, 32'd0, 5'd8, "remu_by0", dn);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "div_ovf", dn);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, "rem_ovf", dn);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, "mulh_min", dn);
        applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd12, "mul_min", dn);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, "mulhsu_ones", dn);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, "mulhu_ones", dn);
        applyStimulus(3'd0, 32'd1234, 32'd5678, 5'd0, "mul_rd0", dn);
        waitDrain();

        $display("[TB] START while busy is ignored");
        applyStimulus(3'd5, 32'd1000, 32'd7, 5'd15, "divu_ignore", dn);
        repeat (5) @(negedge CLK);
        FUNC  = 3'd0;
        DATA1 = 32'hDEAD_BEEF;
        DATA2 = 32'h1234_5678;
        RD_IN = 5'd31;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checkOutput("busy_held", 32'(BUSY), 32'd1);
        waitDrain();

        $display("[TB] back-to-back issue in the DONE cycle");
        applyStimulus(3'd4, 32'd200, 32'hFFFF_FFFD, 5'd16, "b2b_first", dn);
        applyStimulus(3'd6, 32'd200, 32'hFFFF_FFFD, 5'd17, "b2b_second", dn);
        checkOutput("b2b_issue_in_done", 32'(dn), 32'd1);
        checkOutput("b2b_accepted", 32'(BUSY), 32'd1);
        waitDrain();

        $display("[TB] reset abandons an operation");
        applyStimulus(3'd4, 32'd12345, 32'd67, 5'd3, "div_abandon", dn);
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        checkOutput("abort_busy",   32'(BUSY),   32'd0);
        checkOutput("abort_done",   32'(DONE),   32'd0);
        checkOutput("abort_result", RESULT,      32'd0);
        checkOutput("abort_rd",     32'(RD_OUT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);

        $display("[TB] RESET wins over START");
        FUNC  = 3'd5;
        DATA1 = 32'd9;
        DATA2 = 32'd3;
        RD_IN = 5'd4;
        START = 1'b1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("reset_vs_start_busy", 32'(BUSY), 32'd0);
        START = 1'b0;
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        $display("[TB] randomized operations");
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pickOperand();
            b = pickOperand();
            applyStimulus(f, a, b, 5'($urandom_range(0, 31)),
                          $sformatf("rand%0d_f%0d", i, f), dn);
        end
        waitDrain();
        repeat (3) @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
